rv32im_decode_stage: RTL and testbench

- Registered instruction-decode stage for the pipelined RV32IM core; sits between the IF/ID pipeline register and the register-file read / hazard logic.
- Accepts one fetched instruction and its PC per cycle through a valid/ready handshake.
- Decodes fields, immediate, format class and legality.
- Buffers decoded bundles in a small in-order queue so a downstream stall does not lose in-flight instructions. Flush support covers branch and jump redirect.

---
 rtl/rv32im_decode_pkg.sv | 47 ++++
 rtl/rv32im_imm_gen.sv | 50 +++++
 rtl/rv32im_decode_stage.sv | 165 ++++++++++++++++
 tb/tb_rv32im_decode_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_decode_pkg.sv
// rv32im_decode_pkg: shared opcodes, funct7 constants, format enum and the
// decoded-bundle payload used by the RV32IM decode stage.
package rv32im_decode_pkg;

   localparam int unsigned DEC_XLEN = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_ZERO   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [DEC_XLEN-1:0] pc;
      logic [6:0]          opcode;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [DEC_XLEN-1:0] imm;
      fmt_e                fmt;
      logic                is_mext;
      logic                illegal;
   } decoded_bundle_t;

endpackage

// File: rtl/rv32im_imm_gen.sv
// rv32im_imm_gen: combinational immediate extraction and format class.
// Ports:
//   inst_i  raw 32-bit instruction
//   imm_o   extended immediate (0 for opcodes without one)
//   fmt_o   format class (fmt_e encoding), FMT_NONE for unknown opcodes
module rv32im_imm_gen
   import rv32im_decode_pkg::*;
(
   input  logic [31:0]         inst_i,
   output logic [DEC_XLEN-1:0] imm_o,
   output logic [2:0]          fmt_o
);

   // Opcode selects both the immediate layout and the format class
   always_comb begin
      imm_o = '0;
      fmt_o = FMT_NONE;
      case (inst_i[6:0])
         OPC_RTYPE: fmt_o = FMT_R;
         OPC_ITYPE, OPC_LOAD, OPC_JALR: begin
            fmt_o = FMT_I;
            imm_o = DEC_XLEN'($signed(inst_i[31:20]));
         end
         OPC_FENCE, OPC_SYSTEM: begin
            fmt_o = FMT_I;
            imm_o = DEC_XLEN'(inst_i[31:20]);
         end
         OPC_STORE: begin
            fmt_o = FMT_S;
            imm_o = DEC_XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
         end
         OPC_BRANCH: begin
            fmt_o = FMT_B;
            imm_o = DEC_XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                                       inst_i[11:8], 1'b0}));
         end
         OPC_JAL: begin
            fmt_o = FMT_J;
            imm_o = DEC_XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                                       inst_i[30:21], 1'b0}));
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt_o = FMT_U;
            imm_o = DEC_XLEN'($signed({inst_i[31:12], 12'h000}));
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rv32im_decode_stage.sv
// rv32im_decode_stage: registered RV32IM decode stage with an in-order
// DEPTH-entry bundle queue and flush.
// Optional feature macro: DECODER_MEXT_EN (OP funct7=0000001 legal, o_is_mext).
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_valid/o_ready      upstream handshake; i_inst, i_pc instruction + address
//   i_flush              drop all queued and incoming instructions
//   o_valid/i_ready      downstream handshake on the head bundle
//   o_pc .. o_illegal    decoded head bundle fields
module rv32im_decode_stage
   import rv32im_decode_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [31:0]     i_inst,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_pc,
   output logic [6:0]      o_opcode,
   output logic [2:0]      o_funct3,
   output logic [6:0]      o_funct7,
   output logic [4:0]      o_rs1_addr,
   output logic [4:0]      o_rs2_addr,
   output logic [4:0]      o_rd_addr,
   output logic [XLEN-1:0] o_imm,
   output logic [2:0]      o_fmt,
   output logic            o_is_mext,
   output logic            o_illegal
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DEC_XLEN-1:0] imm_c;
   logic [2:0]          fmt_c;
   logic [6:0]          opcode_c;
   logic [2:0]          funct3_c;
   logic [6:0]          funct7_c;
   logic                illegal_c;
   logic                is_mext_c;
   decoded_bundle_t     bundle_d;

   decoded_bundle_t     mem_q [DEPTH];
   decoded_bundle_t     head_c;
   logic [PTR_W-1:0]    head_q, tail_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                push_c, pop_c;

   assign opcode_c = i_inst[6:0];
   assign funct3_c = i_inst[14:12];
   assign funct7_c = i_inst[31:25];

   rv32im_imm_gen u_imm_gen (
      .inst_i (i_inst),
      .imm_o  (imm_c),
      .fmt_o  (fmt_c)
   );

   // Legality; every known opcode ends in 2'b11, so a bad inst[1:0]
   // always falls into the unknown-opcode default
   always_comb begin
      illegal_c = 1'b0;
      is_mext_c = 1'b0;
      case (opcode_c)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE, OPC_SYSTEM: illegal_c = 1'b0;
         OPC_JALR:   illegal_c = (funct3_c != 3'b000);
         OPC_BRANCH: illegal_c = (funct3_c inside {3'b010, 3'b011});
         OPC_LOAD:   illegal_c = (funct3_c inside {3'b011, 3'b110, 3'b111});
         OPC_STORE:  illegal_c = (funct3_c >= 3'b011);
         OPC_ITYPE: begin
            if (funct3_c == 3'b001)
               illegal_c = (funct7_c != F7_ZERO);
            else if (funct3_c == 3'b101)
               illegal_c = !(funct7_c inside {F7_ZERO, F7_ALT});
         end
         OPC_RTYPE: begin
            case (funct7_c)
               F7_ZERO:   illegal_c = 1'b0;
               F7_ALT:    illegal_c = !(funct3_c inside {3'b000, 3'b101});
`ifdef DECODER_MEXT_EN
               F7_MULDIV: is_mext_c = 1'b1;
`else
               F7_MULDIV: illegal_c = 1'b1;
`endif
               default:   illegal_c = 1'b1;
            endcase
         end
         default: illegal_c = 1'b1;
      endcase
   end

   // Illegal encodings are still enqueued, but carry no format or immediate
   always_comb begin
      bundle_d         = '0;
      bundle_d.pc      = DEC_XLEN'(i_pc);
      bundle_d.opcode  = opcode_c;
      bundle_d.funct3  = funct3_c;
      bundle_d.funct7  = funct7_c;
      bundle_d.rs1     = i_inst[19:15];
      bundle_d.rs2     = i_inst[24:20];
      bundle_d.rd      = i_inst[11:7];
      bundle_d.imm     = illegal_c ? '0 : imm_c;
      bundle_d.fmt     = illegal_c ? FMT_NONE : fmt_e'(fmt_c);
      bundle_d.is_mext = is_mext_c;
      bundle_d.illegal = illegal_c;
   end

   // Ready depends only on the registered occupancy: no bypass when full
   assign o_ready = (count_q != CNT_W'(DEPTH));
   assign o_valid = (count_q != '0);
   assign push_c  = i_valid && o_ready;
   assign pop_c   = o_valid && i_ready;

   always_comb begin
      count_d = count_q;
      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Queue state; reset beats flush, flush beats push/pop.
   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (i_flush) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push_c) begin
            mem_q[tail_q] <= bundle_d;
            tail_q        <= tail_q + PTR_W'(1);
         end
         if (pop_c) head_q <= head_q + PTR_W'(1);
      end
   end

   assign head_c     = mem_q[head_q];
   assign o_pc       = XLEN'(head_c.pc);
   assign o_opcode   = head_c.opcode;
   assign o_funct3   = head_c.funct3;
   assign o_funct7   = head_c.funct7;
   assign o_rs1_addr = head_c.rs1;
   assign o_rs2_addr = head_c.rs2;
   assign o_rd_addr  = head_c.rd;
   assign o_imm      = XLEN'($signed(head_c.imm));
   assign o_fmt      = head_c.fmt;
   assign o_is_mext  = head_c.is_mext;
   assign o_illegal  = head_c.illegal;

endmodule

// File: tb/tb_rv32im_decode_stage.sv
// tb_rv32im_decode_stage: directed and random stimulus for the RV32IM
// decode stage, checked against a queue-based reference model.
module tb_rv32im_decode_stage;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            valid_in = 1'b0;
   logic            ready_out;
   logic [31:0]     inst = '0;
   logic [XLEN-1:0] pc = '0;
   logic            flush = 1'b0;
   logic            valid_out;
   logic            ready_in = 1'b0;
   logic [XLEN-1:0] o_pc, o_imm;
   logic [6:0]      o_opcode, o_funct7;
   logic [2:0]      o_funct3, o_fmt;
   logic [4:0]      o_rs1, o_rs2, o_rd;
   logic            o_is_mext, o_illegal;

   int compared   = 0;
   int mismatched = 0;

`ifdef DECODER_MEXT_EN
   localparam bit MEXT = 1'b1;
`else
   localparam bit MEXT = 1'b0;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        illegal;
      logic        mext;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   rv32im_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_valid    (valid_in),
      .o_ready    (ready_out),
      .i_inst     (inst),
      .i_pc       (pc),
      .i_flush    (flush),
      .o_valid    (valid_out),
      .i_ready    (ready_in),
      .o_pc       (o_pc),
      .o_opcode   (o_opcode),
      .o_funct3   (o_funct3),
      .o_funct7   (o_funct7),
      .o_rs1_addr (o_rs1),
      .o_rs2_addr (o_rs2),
      .o_rd_addr  (o_rd),
      .o_imm      (o_imm),
      .o_fmt      (o_fmt),
      .o_is_mext  (o_is_mext),
      .o_illegal  (o_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference decode written straight from the instruction-set rules
   function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p);
      exp_t e;
      int   f3 = int'(i[14:12]);
      int   f7 = int'(i[31:25]);
      e.pc = p; e.inst = i; e.imm = 0; e.fmt = 3'd7; e.illegal = 1'b0; e.mext = 1'b0;
      case (i[6:0])
         7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = {i[31:12], 12'h000}; end
         7'h6F: begin
            e.fmt = 3'd5;
            e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
         end
         7'h67: begin e.fmt = 3'd1; e.imm = 32'($signed(i[31:20])); e.illegal = (f3 != 0); end
         7'h63: begin
            e.fmt = 3'd3;
            e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            e.illegal = (f3 == 2 || f3 == 3);
         end
         7'h03: begin e.fmt = 3'd1; e.imm = 32'($signed(i[31:20])); e.illegal = (f3 == 3 || f3 >= 6); end
         7'h23: begin e.fmt = 3'd2; e.imm = 32'($signed({i[31:25], i[11:7]})); e.illegal = (f3 >= 3); end
         7'h13: begin
            e.fmt = 3'd1; e.imm = 32'($signed(i[31:20]));
            if (f3 == 1) e.illegal = (f7 != 0);
            if (f3 == 5) e.illegal = !(f7 == 0 || f7 == 32);
         end
         7'h33: begin
            e.fmt = 3'd0;
            if (f7 == 32) e.illegal = !(f3 == 0 || f3 == 5);
            else if (f7 == 1) begin e.illegal = !MEXT; e.mext = MEXT; end
            else if (f7 != 0) e.illegal = 1'b1;
         end
         7'h0F, 7'h73: begin e.fmt = 3'd1; e.imm = {20'h0, i[31:20]}; end
         default: e.illegal = 1'b1;
      endcase
      if (e.illegal) begin e.fmt = 3'd7; e.imm = 0; end
      return e;
   endfunction

   task automatic check_outputs();
      exp_t e;
      chk("ready", 32'(ready_out), 32'(exp_q.size() < int'(DEPTH)));
      chk("valid", 32'(valid_out), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         e = exp_q[0];
         chk("pc", o_pc, e.pc);
         chk("opcode", 32'(o_opcode), 32'(e.inst[6:0]));
         chk("funct3", 32'(o_funct3), 32'(e.inst[14:12]));
         chk("funct7", 32'(o_funct7), 32'(e.inst[31:25]));
         chk("rs1", 32'(o_rs1), 32'(e.inst[19:15]));
         chk("rs2", 32'(o_rs2), 32'(e.inst[24:20]));
         chk("rd", 32'(o_rd), 32'(e.inst[11:7]));
         chk("imm", o_imm, e.imm);
         chk("fmt", 32'(o_fmt), 32'(e.fmt));
         chk("mext", 32'(o_is_mext), 32'(e.mext));
         chk("illegal", 32'(o_illegal), 32'(e.illegal));
      end
   endtask

   task automatic model_update();
      bit do_push, do_pop;
      if (rst || flush) begin
         exp_q.delete();
      end else begin
         do_push = valid_in && (exp_q.size() < int'(DEPTH));
         do_pop  = (exp_q.size() != 0) && ready_in;
         if (do_pop) exp_q.delete(0);
         if (do_push) exp_q.push_back(ref_decode(inst, pc));
      end
   endtask

   // One clock: check on the falling edge, advance model, step past rising edge
   task automatic tick();
      @(negedge clk);
      check_outputs();
      model_update();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] r = $urandom;
      int sel = $urandom_range(0, 12);
      case (sel)
         0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h6F;
         3: r[6:0] = 7'h67;  4: r[6:0] = 7'h63;  5: r[6:0] = 7'h03;
         6: r[6:0] = 7'h23;  7: r[6:0] = 7'h13;  8: r[6:0] = 7'h33;
         9: r[6:0] = 7'h0F; 10: r[6:0] = 7'h73;
         default: ;
      endcase
      if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
         endcase
      end
      return r;
   endfunction

   initial begin
      // Reset
      rst = 1'b1;
      @(posedge clk); #1;
      tick();
      rst = 1'b0;
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_ready", 32'(ready_out), 32'd1);
      chk("rst_pc", o_pc, 32'd0);
      chk("rst_imm", o_imm, 32'd0);
      chk("rst_opcode", 32'(o_opcode), 32'd0);
      chk("rst_fmt", 32'(o_fmt), 32'd0);
      chk("rst_illegal", 32'(o_illegal), 32'd0);

      // addi x1,x2,-1
      ready_in = 1'b1; valid_in = 1'b1; inst = 32'hFFF10093; pc = 32'h100;
      tick();
      valid_in = 1'b0;
      chk("addi_valid", 32'(valid_out), 32'd1);
      chk("addi_rd", 32'(o_rd), 32'd1);
      chk("addi_rs1", 32'(o_rs1), 32'd2);
      chk("addi_imm", o_imm, 32'hFFFFFFFF);
      chk("addi_fmt", 32'(o_fmt), 32'd1);
      chk("addi_illegal", 32'(o_illegal), 32'd0);
      chk("addi_pc", o_pc, 32'h100);
      tick();

      // beq x0,x0,-4 then jal x0,0
      valid_in = 1'b1; inst = 32'hFE000EE3; pc = 32'h104;
      tick();
      valid_in = 1'b0;
      chk("beq_imm", o_imm, 32'hFFFFFFFC);
      chk("beq_fmt", 32'(o_fmt), 32'd3);
      tick();
      valid_in = 1'b1; inst = 32'h0000006F; pc = 32'h108;
      tick();
      valid_in = 1'b0;
      chk("jal_imm", o_imm, 32'd0);
      chk("jal_fmt", 32'(o_fmt), 32'd5);
      tick();

      // mul x3,x1,x2
      valid_in = 1'b1; inst = 32'h022081B3; pc = 32'h10C;
      tick();
      valid_in = 1'b0;
      chk("mul_rd", 32'(o_rd), 32'd3);
`ifdef DECODER_MEXT_EN
      chk("mul_mext", 32'(o_is_mext), 32'd1);
      chk("mul_illegal", 32'(o_illegal), 32'd0);
      chk("mul_fmt", 32'(o_fmt), 32'd0);
`else
      chk("mul_mext", 32'(o_is_mext), 32'd0);
      chk("mul_illegal", 32'(o_illegal), 32'd1);
      chk("mul_fmt", 32'(o_fmt), 32'd7);
`endif
      tick();

      // Backpressure: A, B fill the queue, C waits
      ready_in = 1'b0;
      valid_in = 1'b1; inst = 32'h00100093; pc = 32'h200; tick();
      inst = 32'h00200113; pc = 32'h204; tick();
      inst = 32'h00300193; pc = 32'h208;
      chk("bp_full_ready", 32'(ready_out), 32'd0);
      tick();
      chk("bp_hold_pc", o_pc, 32'h200);
      ready_in = 1'b1;
      tick();
      chk("bp_pop_a_pc", o_pc, 32'h204);
      chk("bp_after_full_ready", 32'(ready_out), 32'd1);
      tick();
      chk("bp_pushpop_pc", o_pc, 32'h208);
      chk("bp_pushpop_valid", 32'(valid_out), 32'd1);
      valid_in = 1'b0;
      tick();
      chk("bp_empty", 32'(valid_out), 32'd0);

      // Flush with a full queue and a concurrent push
      ready_in = 1'b0;
      valid_in = 1'b1; inst = 32'h00400213; pc = 32'h300; tick();
      inst = 32'h00500293; pc = 32'h304; tick();
      flush = 1'b1; inst = 32'h00600313; pc = 32'h308;
      tick();
      flush = 1'b0; valid_in = 1'b0;
      chk("flush_valid", 32'(valid_out), 32'd0);
      chk("flush_ready", 32'(ready_out), 32'd1);
      tick();
      chk("flush_dropped", 32'(valid_out), 32'd0);

      // All-zero word is illegal
      valid_in = 1'b1; inst = 32'h00000000; pc = 32'h400;
      tick();
      valid_in = 1'b0;
      chk("zero_illegal", 32'(o_illegal), 32'd1);
      chk("zero_fmt", 32'(o_fmt), 32'd7);
      chk("zero_imm", o_imm, 32'd0);

      // Reset mid-stream
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_valid", 32'(valid_out), 32'd0);
      chk("rst_mid_illegal", 32'(o_illegal), 32'd0);

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         valid_in = ($urandom_range(0, 99) < 65);
         ready_in = ($urandom_range(0, 99) < 55);
         flush    = ($urandom_range(0, 99) < 4);
         rst      = ($urandom_range(0, 199) < 1);
         inst     = rand_inst();
         pc       = {$urandom} & 32'hFFFF_FFFC;
         tick();
      end
      valid_in = 1'b0; flush = 1'b0; rst = 1'b0; ready_in = 1'b1;
      for (int n = 0; n < 4; n++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
